// File: rtl/imem_loadable.sv
// Loadable instruction memory for the 16-bit core.
// Clears itself to NOP after reset, accepts a streamed program over a
// valid/ready handshake, then serves registered fetches with 1-cycle latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | writing NOP_WORD to every address, one per cycle
// S_RUN   | serving fetches; load_start enters S_LOAD
// S_LOAD  | accepting program words; fetches are dropped
module imem_loadable #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_end,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  overflow,
  output logic                  addr_fault,
  output logic                  busy
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      clr_ptr_q;
  logic [PTR_W-1:0]      load_ptr_q;
  logic [DATA_WIDTH-1:0] instruction_q;
  logic                  fetch_valid_q;
  logic                  overflow_q;
  logic                  addr_fault_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we_d;
  logic [IDX_W-1:0]      mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  fetch_in_range;
  logic                  load_has_room;

  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_P);
  assign load_has_room  = (load_ptr_q < DEPTH_P);

  // Single write port shared by the clear sweep and the program loader.
  // A load_start in LOAD takes precedence and the coincident word is dropped.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = NOP_WORD;
    if (!reset) begin
      case (state_q)
        S_CLEAR: begin
          mem_we_d    = 1'b1;
          mem_waddr_d = clr_ptr_q[IDX_W-1:0];
        end
        S_LOAD: begin
          if (load_valid && !load_start && load_has_room) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = load_ptr_q[IDX_W-1:0];
            mem_wdata_d = load_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage array; contents are only ever changed through the write port.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Controller: state sequencing, registered fetch path, load bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      clr_ptr_q     <= '0;
      load_ptr_q    <= '0;
      instruction_q <= NOP_WORD;
      fetch_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          fetch_valid_q <= 1'b0;
          clr_ptr_q     <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_P) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          fetch_valid_q <= fetch_req;
          if (fetch_req) begin
            if (fetch_in_range) begin
              instruction_q <= mem_q[fetch_addr[IDX_W-1:0]];
            end else begin
              instruction_q <= NOP_WORD;
              addr_fault_q  <= 1'b1;
            end
          end
          if (load_start) begin
            state_q    <= S_LOAD;
            load_ptr_q <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_LOAD: begin
          fetch_valid_q <= 1'b0;
          if (load_start) begin
            load_ptr_q <= '0;
            overflow_q <= 1'b0;
          end else if (load_valid) begin
            if (load_has_room) begin
              load_ptr_q <= load_ptr_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (load_end) begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q   <= S_CLEAR;
          clr_ptr_q <= '0;
        end
      endcase
    end
  end

  // The write pointer never passes DEPTH, so it doubles as the saturating count.
  assign load_count  = load_ptr_q;
  assign instruction = instruction_q;
  assign fetch_valid = fetch_valid_q;
  assign overflow    = overflow_q;
  assign addr_fault  = addr_fault_q;
  assign fetch_ready = (state_q == S_RUN);
  assign load_ready  = (state_q == S_LOAD);
  assign busy        = (state_q != S_RUN);

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: two instances (DEPTH 256 and DEPTH 16) share the
// same stimulus; a reference model of each memory predicts every output.
module tb_imem_loadable;

  localparam int DA = 256;
  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_end;

  logic        a_fetch_ready, a_fetch_valid, a_load_ready, a_overflow, a_addr_fault, a_busy;
  logic [15:0] a_instruction;
  logic [16:0] a_load_count;
  logic        b_fetch_ready, b_fetch_valid, b_load_ready, b_overflow, b_addr_fault, b_busy;
  logic [15:0] b_instruction;
  logic [16:0] b_load_count;

  imem_loadable #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DA), .NOP_WORD(16'h0000)) dut_a (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(a_fetch_ready), .fetch_valid(a_fetch_valid), .instruction(a_instruction),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_load_ready), .load_end(load_end), .load_count(a_load_count),
    .overflow(a_overflow), .addr_fault(a_addr_fault), .busy(a_busy)
  );

  imem_loadable #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DB), .NOP_WORD(16'h0000)) dut_b (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(b_fetch_ready), .fetch_valid(b_fetch_valid), .instruction(b_instruction),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_load_ready), .load_end(load_end), .load_count(b_load_count),
    .overflow(b_overflow), .addr_fault(b_addr_fault), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [15:0] mem_a [DA];
  logic [15:0] mem_b [DB];
  int          cnt_a, cnt_b;
  bit          ovf_a, ovf_b, flt_a, flt_b;
  logic [15:0] ins_a, ins_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DA; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < DB; i++) mem_b[i] = 16'h0000;
    cnt_a = 0; cnt_b = 0;
    ovf_a = 0; ovf_b = 0;
    flt_a = 0; flt_b = 0;
    ins_a = 16'h0000; ins_b = 16'h0000;
  endtask

  task automatic do_reset();
    int ca, cb, guard;
    reset = 1'b1; fetch_req = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    chk("rst_busy_a", a_busy, 1);
    chk("rst_fready_a", a_fetch_ready, 0);
    chk("rst_lready_a", a_load_ready, 0);
    chk("rst_fvalid_a", a_fetch_valid, 0);
    chk("rst_instr_a", a_instruction, 16'h0000);
    chk("rst_lcount_a", a_load_count, 0);
    chk("rst_ovf_a", a_overflow, 0);
    chk("rst_fault_a", a_addr_fault, 0);
    chk("rst_busy_b", b_busy, 1);
    chk("rst_lcount_b", b_load_count, 0);
    ca = 0; cb = 0; guard = 0;
    while ((a_busy || b_busy) && guard < 1000) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      guard++;
      tick();
    end
    chk("clear_len_a", ca, DA);
    chk("clear_len_b", cb, DB);
    chk("run_fready_a", a_fetch_ready, 1);
    chk("run_fready_b", b_fetch_ready, 1);
  endtask

  task automatic model_fetch(input logic [15:0] addr);
    if (addr < DA) ins_a = mem_a[addr];
    else begin ins_a = 16'h0000; flt_a = 1; end
    if (addr < DB) ins_b = mem_b[addr];
    else begin ins_b = 16'h0000; flt_b = 1; end
  endtask

  task automatic fetch_cycle(input bit req, input logic [15:0] addr);
    fetch_req = req;
    fetch_addr = addr;
    tick();
    if (req) model_fetch(addr);
    chk("fvalid_a", a_fetch_valid, 32'(req));
    chk("instr_a", a_instruction, ins_a);
    chk("fault_a", a_addr_fault, 32'(flt_a));
    chk("fvalid_b", b_fetch_valid, 32'(req));
    chk("instr_b", b_instruction, ins_b);
    chk("fault_b", b_addr_fault, 32'(flt_b));
  endtask

  task automatic model_load_word(input logic [15:0] w);
    if (cnt_a < DA) begin mem_a[cnt_a] = w; cnt_a++; end else ovf_a = 1;
    if (cnt_b < DB) begin mem_b[cnt_b] = w; cnt_b++; end else ovf_b = 1;
  endtask

  task automatic load_words(input logic [15:0] words[$], input bit end_with_last,
                            input bit hold_fetch, input bit rand_gaps,
                            input bit fetch_at_start, input logic [15:0] start_addr);
    int n;
    n = words.size();
    load_start = 1'b1;
    fetch_req = fetch_at_start;
    fetch_addr = start_addr;
    tick();
    load_start = 1'b0;
    if (fetch_at_start) begin
      model_fetch(start_addr);
      chk("start_fvalid_a", a_fetch_valid, 1);
      chk("start_instr_a", a_instruction, ins_a);
      chk("start_instr_b", b_instruction, ins_b);
    end
    cnt_a = 0; cnt_b = 0; ovf_a = 0; ovf_b = 0;
    chk("load_lready_a", a_load_ready, 1);
    chk("load_fready_a", a_fetch_ready, 0);
    chk("load_busy_a", a_busy, 1);
    chk("load_fready_b", b_fetch_ready, 0);
    fetch_req = hold_fetch;
    fetch_addr = 16'h0001;
    for (int i = 0; i < n; i++) begin
      if (rand_gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        tick();
        chk("gap_fvalid_a", a_fetch_valid, 0);
      end
      load_valid = 1'b1;
      load_data = words[i];
      load_end = end_with_last && (i == n - 1);
      tick();
      model_load_word(words[i]);
      chk("ld_fvalid_a", a_fetch_valid, 0);
      chk("ld_fvalid_b", b_fetch_valid, 0);
    end
    load_valid = 1'b0;
    if (!(end_with_last && n > 0)) begin
      load_end = 1'b1;
      tick();
      chk("end_fvalid_a", a_fetch_valid, 0);
    end
    load_end = 1'b0;
    fetch_req = 1'b0;
    chk("end_fready_a", a_fetch_ready, 1);
    chk("end_lready_a", a_load_ready, 0);
    chk("end_busy_a", a_busy, 0);
    chk("end_fready_b", b_fetch_ready, 1);
    chk("lcount_a", a_load_count, cnt_a);
    chk("ovf_a", a_overflow, 32'(ovf_a));
    chk("lcount_b", b_load_count, cnt_b);
    chk("ovf_b", b_overflow, 32'(ovf_b));
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 50) return 16'($urandom_range(0, 15));
    else if (r < 85) return 16'($urandom_range(16, 255));
    else return 16'($urandom);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_end = 1'b0;

    // reset clear, then fetches of cleared memory
    do_reset();
    fetch_cycle(1, 16'h0000);
    fetch_cycle(1, 16'h0080);
    fetch_cycle(1, 16'h00FF);
    fetch_cycle(0, 16'h0000);

    // load a small program and fetch back-to-back
    q = '{16'hA002, 16'hA202, 16'hA400, 16'hA601, 16'h0800, 16'h2580, 16'hC3FE, 16'h8800};
    load_words(q, 0, 0, 0, 0, 16'h0000);
    fetch_cycle(1, 16'd4);
    fetch_cycle(1, 16'd5);
    fetch_cycle(1, 16'd6);
    fetch_cycle(0, 16'd0);

    // overflow on the DEPTH=16 instance, fetch held high during the load
    q.delete();
    for (int i = 0; i < 18; i++) q.push_back(16'h1000 + 16'(i));
    load_words(q, 0, 1, 0, 0, 16'h0000);
    fetch_cycle(1, 16'd0);
    fetch_cycle(1, 16'd15);
    fetch_cycle(1, 16'd16);
    fetch_cycle(0, 16'd0);

    // out-of-range fetch on the DEPTH=256 instance, fault is sticky
    fetch_cycle(1, 16'h0100);
    fetch_cycle(1, 16'h0002);
    fetch_cycle(0, 16'h0000);

    // last word coincides with load_end; fetch serviced in the load_start cycle
    q = '{16'h1111, 16'h2222, 16'h3333, 16'hBEEF};
    load_words(q, 1, 0, 0, 1, 16'h0005);
    fetch_cycle(1, 16'd3);
    fetch_cycle(1, 16'd2);
    fetch_cycle(0, 16'd0);

    // randomized loads and fetches
    for (int r = 0; r < 8; r++) begin
      int n;
      bit ewl;
      q.delete();
      n = int'($urandom_range(0, 24));
      for (int i = 0; i < n; i++) q.push_back(16'($urandom));
      ewl = (n > 0) && ($urandom_range(0, 1) == 1);
      load_words(q, ewl, 1'($urandom_range(0, 1)), 1, 0, 16'h0000);
      for (int k = 0; k < 20; k++) fetch_cycle(1'($urandom_range(0, 3) != 0), rand_addr());
    end

    // reset in the middle of a load wipes partial content
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data = 16'h5A00 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) fetch_cycle(1, 16'(i));
    fetch_cycle(0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, synchronous, writable instruction memory replacing the fixed combinational program ROM of the 16-bit core.
- Sits between the fetch stage (PC -> instruction) and a program loader (UART/bench streaming words).
- Clears itself to NOP on reset, accepts a streamed program over a valid/ready handshake, then serves fetches with 1-cycle latency.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 16, fetch address width (PC width).
- DEPTH, 256, number of stored words. Constraint: DEPTH <= 2**ADDR_WIDTH and DEPTH >= 2.
- NOP_WORD, 16'h0000, clear/fill value (add r0,r0 encoding).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request, sampled when fetch_ready=1.
- fetch_addr  in  ADDR_WIDTH  word address (PC).
- fetch_ready  out  1  memory able to accept a fetch.
- fetch_valid  out  1  instruction holds the result of the fetch accepted on the previous cycle.
- instruction  out  DATA_WIDTH  fetched word, registered.
- load_start  in  1  pulse: enter LOAD mode, write pointer reset to 0.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_WIDTH  program word.
- load_ready  out  1  LOAD mode active, word accepted when load_valid=1.
- load_end  in  1  pulse: leave LOAD mode.
- load_count  out  ADDR_WIDTH+1  words written in the current/last load.
- overflow  out  1  sticky: word offered beyond DEPTH during a load.
- addr_fault  out  1  sticky: fetch with fetch_addr >= DEPTH.
- busy  out  1  high in CLEAR or LOAD.

Behaviour:
- Single clock domain; reset is synchronous and active-high. Port names are clk and reset.
- Reset values: state=CLEAR, clr_ptr=0, instruction=NOP_WORD, fetch_valid=0, load_count=0, overflow=0, addr_fault=0. busy=1, fetch_ready=0 and load_ready=0 follow from the state.
- Reset has priority in any state. Reset mid-CLEAR or mid-LOAD restarts CLEAR from address 0, and all partially loaded content is wiped.
- State CLEAR:
  - Each cycle writes mem[clr_ptr]=NOP_WORD and increments clr_ptr.
  - After writing address DEPTH-1, moves to RUN the next cycle. CLEAR therefore lasts exactly DEPTH cycles.
  - fetch_req, load_start, load_valid and load_end are ignored.
- State RUN:
  - fetch_ready=1.
  - fetch_req=1 at edge N gives fetch_valid=1 after edge N+1, with instruction=mem[fetch_addr].
  - If fetch_addr >= DEPTH, instruction=NOP_WORD and addr_fault is set (sticky until reset).
  - fetch_req=0 gives fetch_valid=0 next cycle, and instruction holds its last value.
  - Back-to-back fetches give one result per cycle.
  - load_start=1: next state LOAD, load_ptr=0, load_count=0, overflow=0. A fetch_req in the same cycle is still serviced.
  - load_valid and load_end are ignored in RUN.
- State LOAD:
  - load_ready=1, fetch_ready=0, fetch_valid=0 the cycle after entry and onward. Fetches are dropped, not queued.
  - load_valid=1 with load_ptr < DEPTH: mem[load_ptr]=load_data, load_ptr++, load_count++.
  - load_valid=1 with load_ptr >= DEPTH: word discarded, overflow=1, load_count saturates at DEPTH, no wrap.
  - load_end=1: next state RUN. If load_valid is also 1 that cycle, the word is written first.
  - Words not rewritten keep their previous contents; no implicit clear.
  - load_start in LOAD restarts the pointer at 0 and clears load_count and overflow.
- Memory reads are synchronous. Write-then-read of the same address across a LOAD->RUN transition returns the new data.
- Arithmetic: pointers are ADDR_WIDTH+1 bits wide, and comparisons are against DEPTH, unsigned.

Test Plan:
- Reset clear: assert reset 1 cycle with DEPTH=256. busy=1 for exactly 256 cycles, then fetch_ready=1. Fetch 0x0000, 0x0080 and 0x00FF each return 0x0000 with fetch_valid one cycle later.
- Load and run: load_start, then stream 0xA002, 0xA202, 0xA400, 0xA601, 0x0800, 0x2580, 0xC3FE, 0x8800, then load_end. load_count=8. Fetches at 4, 5 and 6 back-to-back return 0x0800, 0x2580 and 0xC3FE on consecutive cycles.
- Overflow (DEPTH=16): stream 18 words 0x1000..0x1011. load_count=16, overflow=1, mem[0]=0x1000 and mem[15]=0x100F. Word 0x1010 does not wrap to address 0.
- Fault: in RUN, fetch 0x0100 with DEPTH=256. instruction=0x0000, fetch_valid=1, addr_fault=1, and addr_fault stays 1 on later valid fetches.
- Handshake corners:
  - fetch_req held during LOAD gives fetch_ready=0 and fetch_valid=0.
  - load_valid and load_end in the same cycle with 0xBEEF at ptr 3: mem[3]=0xBEEF and state is RUN next cycle.
- Reset mid-load: after 5 words, assert reset. CLEAR runs a full DEPTH cycles, then mem[0..4] read 0x0000 and load_count=0.
